register_dump_unit: RTL and testbench
=====================================

Name: register_dump_unit

Overview:
- Debug-side initiator for the decode stage's register read port.
- On request, it halts the pipeline and waits for in-flight writebacks to drain.
- It then reads every architectural register through the debug address/data port and streams each word out as bytes over a valid/ready byte interface (UART TX path).
- It releases the halt when the dump finishes.

Parameters:
- NUM_REGS, 32, number of registers dumped, addresses 0..NUM_REGS-1.
- NB_ADDR, 5, register address width.
- NB_DATA, 32, register width; must be a multiple of 8; BYTES = NB_DATA/8.
- DRAIN_CYCLES, 4, cycles held in halt before the first read, so writeback can retire. Must be ≥1.

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  dump request pulse; sampled only in IDLE.
- o_halt  out  1  pipeline halt; also selects the debug read address in decode.
- o_r_addr  out  NB_ADDR  register address driven to decode's debug read port.
- i_r_data  in  NB_DATA  combinational register read data for o_r_addr.
- o_tx_data  out  8  byte to transmitter.
- o_tx_valid  out  1  o_tx_data valid.
- i_tx_ready  in  1  transmitter accepts byte; transfer when o_tx_valid && i_tx_ready at a rising edge.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse at dump completion.

Behaviour:
Reset:
- Clock and reset are as decided: one clock; reset is asynchronous and active-low.
- i_reset_n low: state=IDLE.
- Outputs: o_halt=0, o_r_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
- Shift register, byte counter and drain counter all cleared.
- Reset mid-dump aborts immediately. No partial byte is retried, and o_halt drops asynchronously.

Registered outputs:
- All outputs are registered; no combinational input-to-output paths.
- o_tx_data is the top byte of the shift register; o_tx_valid=1 only in SEND.

FSM:
- IDLE: on i_start=1 → DRAIN. Same edge: o_halt←1, o_r_addr←0, drain counter←0.
- DRAIN:
  - Counter increments each cycle.
  - At DRAIN_CYCLES-1 → READ.
  - o_halt stays 1 from here until DONE exits.
- READ:
  - One cycle. o_r_addr is stable, so capture i_r_data into the shift register and set byte counter←0. → SEND.
- SEND (byte emission order is MSB byte first):
  - o_tx_valid=1.
  - While i_tx_ready=0: stay; o_tx_data and o_tx_valid held stable.
  - On handshake: shift left 8, byte counter++.
  - On the handshake with byte counter = BYTES-1:
    - o_r_addr = NUM_REGS-1 → DONE.
    - Otherwise o_r_addr++ and → READ.
  - o_tx_valid drops for the READ cycle between words; there are no back-to-back bytes across registers.
- DONE: o_done=1 for this cycle; o_halt←0, o_r_addr←0 at exit; → IDLE.

Boundary conditions:
- i_start while o_busy=1 is ignored. No queueing.
- i_start in the same cycle as DONE is ignored. A new dump needs i_start in IDLE.
- o_r_addr does not wrap: its terminal value is NUM_REGS-1.
- i_tx_ready held high in READ/DRAIN has no effect (o_tx_valid=0).
- A ready-only pulse with o_tx_valid=0 is not a transfer.
- Register writes arriving during DRAIN are legal; values after DRAIN are the ones dumped.

Timing (ready always high, DRAIN_CYCLES=4, start sampled edge 0):
- DRAIN occupies cycles 1-4.
- Register k: READ at cycle 5+5k, bytes at 6+5k..9+5k.
- DONE at cycle 165; o_halt low from cycle 166.
- Total dump length with continuous ready: DRAIN_CYCLES + NUM_REGS*(BYTES+1) + 1 cycles.

Test Plan:
- Full dump, ready constant 1, reg[k]=0xA5000000|k: byte stream is A5 00 00 00, A5 00 00 01, …, A5 00 00 1F (128 bytes); o_done at cycle 165; o_halt high in cycles 1-165 exactly.
- Backpressure, ready toggling 1-of-3 cycles: byte sequence is identical to the first test; o_tx_data never changes while o_tx_valid=1 && i_tx_ready=0; o_halt stays 1 throughout.
- o_r_addr ordering: at each READ cycle o_r_addr equals the number of previous READs (0..31); it never exceeds 31; it is 0 after DONE.
- i_start pulsed at cycles 3, 50 and 165: only one dump occurs (128 bytes, single o_done); the pulse at 166 (IDLE) starts a second dump.
- Async reset asserted mid-SEND of register 7, byte 2, between clock edges: outputs go to 0 immediately without a clock edge, state returns to IDLE; after release, a new i_start produces a complete dump from register 0.
- Writeback during drain: a write of 0x12345678 to reg 3 is presented at cycle 2; the dumped bytes for reg 3 are 12 34 56 78.

Source files
------------

// File: rtl/register_dump_unit_if.sv
// Bundles decode's debug register read port with the byte-wide valid/ready
// transmit channel towards the UART TX path.
interface register_dump_unit_if #(
  parameter int NB_ADDR = 5,
  parameter int NB_DATA = 32
);
  logic [NB_ADDR-1:0] o_r_addr;
  logic [NB_DATA-1:0] i_r_data;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;

  modport master (
    output o_r_addr,
    input  i_r_data,
    output o_tx_data,
    output o_tx_valid,
    input  i_tx_ready
  );

  modport slave (
    input  o_r_addr,
    output i_r_data,
    input  o_tx_data,
    input  o_tx_valid,
    output i_tx_ready
  );
endinterface

// File: rtl/register_dump_unit.sv
// Debug initiator: halts the pipeline, lets writeback drain, then reads every
// architectural register and streams it MSB byte first over valid/ready.
module register_dump_unit #(
  parameter int NUM_REGS     = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_DATA      = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  output logic                 o_halt,
  output logic                 o_busy,
  output logic                 o_done,
  register_dump_unit_if.master bus
);

  localparam int BYTES   = NB_DATA / 8;
  localparam int NB_BCNT = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int NB_DCNT = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [NB_BCNT-1:0] LAST_BYTE  = NB_BCNT'(BYTES - 1);
  localparam logic [NB_DCNT-1:0] DRAIN_LAST = NB_DCNT'(DRAIN_CYCLES - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR  = NB_ADDR'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRAIN = 3'd1,
    ST_READ  = 3'd2,
    ST_SEND  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [NB_DCNT-1:0]   drain_cnt_r;
  logic [NB_BCNT-1:0]   byte_cnt_r;
  logic [NB_DATA-1:0]   shift_r;
  logic [NB_ADDR-1:0]   addr_r;
  logic                 halt_r;
  logic                 busy_r;
  logic                 valid_r;
  logic                 done_r;

  logic                 start_s;
  logic                 drain_end_s;
  logic                 xfer_s;
  logic                 last_byte_s;
  logic                 last_reg_s;

  // A transfer only counts in SEND, where the registered valid is high.
  assign start_s     = (state_r == ST_IDLE) && i_start;
  assign drain_end_s = (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_LAST);
  assign xfer_s      = (state_r == ST_SEND) && valid_r && bus.i_tx_ready;
  assign last_byte_s = xfer_s && (byte_cnt_r == LAST_BYTE);
  assign last_reg_s  = (addr_r == LAST_ADDR);

  // Next-state decode for the dump sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_s = ST_DRAIN;
        else         state_s = ST_IDLE;
      end
      ST_DRAIN: begin
        if (drain_end_s) state_s = ST_READ;
        else             state_s = ST_DRAIN;
      end
      ST_READ: state_s = ST_SEND;
      ST_SEND: begin
        if (last_byte_s) begin
          if (last_reg_s) state_s = ST_DONE;
          else            state_s = ST_READ;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status outputs are registered copies of the state being entered.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      halt_r  <= 1'b0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      halt_r  <= (state_s != ST_IDLE);
      busy_r  <= (state_s != ST_IDLE);
      valid_r <= (state_s == ST_SEND);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Drain counter: restarts on every accepted request, stops at its terminal count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      drain_cnt_r <= {NB_DCNT{1'b0}};
    end else if (start_s) begin
      drain_cnt_r <= {NB_DCNT{1'b0}};
    end else if ((state_r == ST_DRAIN) && !drain_end_s) begin
      drain_cnt_r <= drain_cnt_r + NB_DCNT'(1);
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  // Word capture and MSB-first byte shifter; the top byte is the TX data.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_r    <= {NB_DATA{1'b0}};
      byte_cnt_r <= {NB_BCNT{1'b0}};
    end else if (state_r == ST_READ) begin
      shift_r    <= bus.i_r_data;
      byte_cnt_r <= {NB_BCNT{1'b0}};
    end else if (xfer_s) begin
      shift_r    <= shift_r << 8;
      byte_cnt_r <= byte_cnt_r + NB_BCNT'(1);
    end else begin
      shift_r    <= shift_r;
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Debug read address: zero at request and at exit, never wraps past the last register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_r <= {NB_ADDR{1'b0}};
    end else if (start_s || (state_r == ST_DONE)) begin
      addr_r <= {NB_ADDR{1'b0}};
    end else if (last_byte_s && !last_reg_s) begin
      addr_r <= addr_r + NB_ADDR'(1);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign o_halt         = halt_r;
  assign o_busy         = busy_r;
  assign o_done         = done_r;
  assign bus.o_r_addr   = addr_r;
  assign bus.o_tx_data  = shift_r[NB_DATA-1 -: 8];
  assign bus.o_tx_valid = valid_r;

endmodule

// File: tb/tb_register_dump_unit.sv
// Self-checking bench for register_dump_unit: scenario table plus a reference
// byte-stream model, with a hand-written asynchronous-reset sequence.
module tb_register_dump_unit;
  localparam int NUM_REGS     = 32;
  localparam int NB_ADDR      = 5;
  localparam int NB_DATA      = 32;
  localparam int DRAIN_CYCLES = 4;
  localparam int BYTES        = NB_DATA / 8;
  localparam int LIMIT        = 4000;

  typedef struct {
    int ready_mode;   // 0 always ready, 1 ready one cycle in three, 2 random
    int data_mode;    // 0 A5000000|k, 1 random, 2 pattern plus drain-time write to reg 3
    bit extra_starts; // pulse i_start at cycles 3, 50 and 165 of the dump
    int exp_done;     // cycle of o_done relative to the start edge, 0 = not fixed
    int exp_bytes;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic halt, busy, done;
  logic [NB_DATA-1:0] regs [NUM_REGS];
  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs [9];

  register_dump_unit_if #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) bus ();

  assign bus.i_r_data   = regs[bus.o_r_addr];
  assign bus.i_tx_ready = ready;

  register_dump_unit #(
    .NUM_REGS(NUM_REGS), .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .o_halt(halt), .o_busy(busy), .o_done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_regs(input int data_mode);
    for (int k = 0; k < NUM_REGS; k++) begin
      if (data_mode == 1) regs[k] = NB_DATA'($urandom);
      else                regs[k] = 32'hA500_0000 | 32'(k);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge just after o_done.
  task automatic run_dump(input vec_t v);
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    logic [7:0] prev_data;
    bit prev_stall;
    bit fin;
    int rel;
    int done_rel;
    fill_regs(v.data_mode);
    check("idle_halt", 64'(halt), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_valid", 64'(bus.o_tx_valid), 64'd0);
    check("idle_addr", 64'(bus.o_r_addr), 64'd0);
    start = 1'b1;
    @(negedge clk);
    rel = 1; fin = 1'b0; done_rel = 0; prev_stall = 1'b0; prev_data = 8'h00;
    while (!fin && rel < LIMIT) begin
      start = v.extra_starts && (rel == 3 || rel == 50 || rel == 165);
      case (v.ready_mode)
        0:       ready = 1'b1;
        1:       ready = (rel % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (v.data_mode == 2 && rel == 2) regs[3] = 32'h1234_5678;
      if (rel == DRAIN_CYCLES + 1) begin
        for (int k = 0; k < NUM_REGS; k++)
          for (int b = 0; b < BYTES; b++)
            exp_q.push_back(8'((regs[k] >> (8 * (BYTES - 1 - b))) & 32'hFF));
      end
      check("halt_high", 64'(halt), 64'd1);
      check("busy_high", 64'(busy), 64'd1);
      check("addr_range", 64'(int'(bus.o_r_addr) > NUM_REGS - 1), 64'd0);
      if (rel <= DRAIN_CYCLES + 1) check("valid_in_drain_read", 64'(bus.o_tx_valid), 64'd0);
      if (prev_stall) begin
        check("stall_valid", 64'(bus.o_tx_valid), 64'd1);
        check("stall_data", 64'(bus.o_tx_data), 64'(prev_data));
      end
      if (bus.o_tx_valid && ready) begin
        check("byte_addr", 64'(bus.o_r_addr), 64'(got_q.size() / BYTES));
        if (got_q.size() < exp_q.size()) check("byte", 64'(bus.o_tx_data), 64'(exp_q[got_q.size()]));
        else check("extra_byte", 64'(got_q.size()), 64'(exp_q.size()));
        got_q.push_back(bus.o_tx_data);
      end
      prev_stall = bus.o_tx_valid && !ready;
      prev_data  = bus.o_tx_data;
      if (done) begin
        fin = 1'b1;
        done_rel = rel;
      end
      @(negedge clk);
      rel++;
    end
    start = 1'b0;
    check("timeout", 64'(fin), 64'd1);
    check("byte_count", 64'(got_q.size()), 64'(v.exp_bytes));
    if (v.exp_done != 0) check("done_cycle", 64'(done_rel), 64'(v.exp_done));
    if (v.data_mode == 2 && got_q.size() >= 16)
      check("reg3_writeback", 64'({got_q[12], got_q[13], got_q[14], got_q[15]}), 64'h1234_5678);
  endtask

  initial begin
    vecs[0] = '{ready_mode: 0, data_mode: 0, extra_starts: 1'b0, exp_done: 165, exp_bytes: 128};
    vecs[1] = '{ready_mode: 1, data_mode: 0, extra_starts: 1'b0, exp_done: 0,   exp_bytes: 128};
    vecs[2] = '{ready_mode: 0, data_mode: 0, extra_starts: 1'b1, exp_done: 165, exp_bytes: 128};
    vecs[3] = '{ready_mode: 0, data_mode: 0, extra_starts: 1'b0, exp_done: 165, exp_bytes: 128};
    vecs[4] = '{ready_mode: 0, data_mode: 2, extra_starts: 1'b0, exp_done: 165, exp_bytes: 128};
    vecs[5] = '{ready_mode: 2, data_mode: 1, extra_starts: 1'b0, exp_done: 0,   exp_bytes: 128};
    vecs[6] = '{ready_mode: 2, data_mode: 1, extra_starts: 1'b0, exp_done: 0,   exp_bytes: 128};
    vecs[7] = '{ready_mode: 1, data_mode: 1, extra_starts: 1'b0, exp_done: 0,   exp_bytes: 128};
    vecs[8] = '{ready_mode: 0, data_mode: 1, extra_starts: 1'b0, exp_done: 165, exp_bytes: 128};
    fill_regs(0);

    #1;
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(bus.o_tx_valid), 64'd0);
    check("rst_data", 64'(bus.o_tx_data), 64'd0);
    check("rst_addr", 64'(bus.o_r_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Rows 2 and 3 run back to back: row 3 starts in the cycle right after DONE.
    for (int i = 0; i < 8; i++) run_dump(vecs[i]);

    // Asynchronous reset in the middle of register 7, byte 2.
    fill_regs(1);
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int r = 1; r < 43; r++) @(negedge clk);
    check("pre_rst_valid", 64'(bus.o_tx_valid), 64'd1);
    check("pre_rst_addr", 64'(bus.o_r_addr), 64'd7);
    check("pre_rst_byte", 64'(bus.o_tx_data), 64'(regs[7][15:8]));
    #2 rst_n = 1'b0;
    #1;
    check("async_halt", 64'(halt), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_valid", 64'(bus.o_tx_valid), 64'd0);
    check("async_data", 64'(bus.o_tx_data), 64'd0);
    check("async_addr", 64'(bus.o_r_addr), 64'd0);
    check("async_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_dump(vecs[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
